encoder_pipeline_scheduler: RTL and testbench

//  Sequences the 3-stage arithmetic-encoder datapath for one frame of symbols.

---
 rtl/encoder_pipeline_scheduler_if.sv | 36 +++
 rtl/encoder_pipeline_scheduler.sv | 107 ++++++++++
 tb/tb_encoder_pipeline_scheduler.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/encoder_pipeline_scheduler_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// encoder_pipeline_scheduler_if: scheduler <-> source/packer/datapath bundle (rev 1.0)
// ----------------------------------------------------------------------------
interface encoder_pipeline_scheduler_if #(
  parameter int CNT_WIDTH = 16
) ();
  logic                 start;
  logic                 in_valid;
  logic                 in_last;
  logic                 in_ready;
  logic                 out_ready;
  logic                 out_valid;
  logic                 en_s1_2;
  logic                 en_s2_3;
  logic                 en_final;
  logic                 enc_init;
  logic                 flush_req;
  logic                 flush_ack;
  logic                 frame_done;
  logic                 busy;
  logic [CNT_WIDTH-1:0] sym_count;

  modport master (
    input  start, in_valid, in_last, out_ready, flush_ack,
    output in_ready, out_valid, en_s1_2, en_s2_3, en_final,
           enc_init, flush_req, frame_done, busy, sym_count
  );

  modport slave (
    output start, in_valid, in_last, out_ready, flush_ack,
    input  in_ready, out_valid, en_s1_2, en_s2_3, en_final,
           enc_init, flush_req, frame_done, busy, sym_count
  );
endinterface
`default_nettype wire

// File: rtl/encoder_pipeline_scheduler.sv
`default_nettype none
// ----------------------------------------------------------------------------
// encoder_pipeline_scheduler: frame sequencer for the 3-stage encoder pipe (rev 1.0)
// ----------------------------------------------------------------------------
module encoder_pipeline_scheduler #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                         general_clk,
  input  logic                         reset,
  encoder_pipeline_scheduler_if.master bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    FLUSH = 2'd3
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  state_t               state;
  logic                 v12;
  logic                 v23;
  logic                 out_valid_q;
  logic                 enc_init_q;
  logic                 flush_req_q;
  logic                 frame_done_q;
  logic [CNT_WIDTH-1:0] sym_count_q;

  logic                 adv;
  logic                 in_ready;
  logic                 accept;

  // One global stall: a held final result freezes every stage.
  assign adv      = !(out_valid_q && !bus.out_ready);
  assign in_ready = adv && (state == RUN);
  assign accept   = bus.in_valid && in_ready;

  always_ff @(posedge general_clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      v12          <= 1'b0;
      v23          <= 1'b0;
      out_valid_q  <= 1'b0;
      enc_init_q   <= 1'b0;
      flush_req_q  <= 1'b0;
      frame_done_q <= 1'b0;
      sym_count_q  <= '0;
    end else begin
      enc_init_q   <= 1'b0;
      frame_done_q <= 1'b0;

      if (adv) begin
        v12         <= accept;
        v23         <= v12;
        out_valid_q <= v23;
      end

      if (accept && (sym_count_q != CNT_MAX)) begin
        sym_count_q <= sym_count_q + CNT_WIDTH'(1);
      end

      case (state)
        IDLE: begin
          if (bus.start) begin
            state       <= RUN;
            enc_init_q  <= 1'b1;
            sym_count_q <= '0;
          end
        end
        RUN: begin
          if (accept && bus.in_last) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (!v12 && !v23 && !out_valid_q) begin
            state       <= FLUSH;
            flush_req_q <= 1'b1;
          end
        end
        FLUSH: begin
          if (bus.flush_ack) begin
            state        <= IDLE;
            flush_req_q  <= 1'b0;
            frame_done_q <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = out_valid_q;
  assign bus.en_s1_2    = accept;
  assign bus.en_s2_3    = adv && v12;
  assign bus.en_final   = adv && v23;
  assign bus.enc_init   = enc_init_q;
  assign bus.flush_req  = flush_req_q;
  assign bus.frame_done = frame_done_q;
  assign bus.busy       = (state != IDLE);
  assign bus.sym_count  = sym_count_q;

endmodule
`default_nettype wire

// File: tb/tb_encoder_pipeline_scheduler.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_encoder_pipeline_scheduler: directed bench with tag scoreboard (rev 1.0)
// ----------------------------------------------------------------------------
module tb_encoder_pipeline_scheduler;

  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  encoder_pipeline_scheduler_if #(.CNT_WIDTH(CW)) bus ();

  encoder_pipeline_scheduler #(.CNT_WIDTH(CW)) dut (
    .general_clk (clk),
    .reset       (rst_n),
    .bus         (bus.master)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0] sb[$];
  logic [7:0] cur_tag = '0;
  logic [7:0] s12_tag = '0, s23_tag = '0, fin_tag = '0;
  logic [7:0] smp_tag = '0;
  logic       smp_en12 = 1'b0, smp_en23 = 1'b0, smp_enf = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Stand-in datapath: tags move through stage registers only on the enables.
  always @(negedge clk) begin
    smp_en12 = bus.en_s1_2;
    smp_en23 = bus.en_s2_3;
    smp_enf  = bus.en_final;
    smp_tag  = cur_tag;
    if (bus.out_valid && bus.out_ready) begin
      chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) chk("sb_order", 32'(fin_tag), 32'(sb.pop_front()));
    end
  end

  always @(posedge clk) begin
    if (smp_en12) s12_tag <= smp_tag;
    if (smp_en23) s23_tag <= s12_tag;
    if (smp_enf)  fin_tag <= s23_tag;
  end

  function automatic logic [8:0] outs();
    return {bus.busy, bus.out_valid, bus.in_ready, bus.en_s1_2, bus.en_s2_3,
            bus.en_final, bus.enc_init, bus.flush_req, bus.frame_done};
  endfunction

  function automatic logic bitat(input logic [31:0] pat, input int len, input int k);
    return (k >= 0 && k < len) ? pat[k] : 1'b0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame();
    bus.start = 1'b1;
    #2;
    chk("enc_init_pre", 32'(bus.enc_init), 32'd0);
    tick();
    bus.start = 1'b0;
    #2;
    chk("enc_init", 32'(bus.enc_init), 32'd1);
    chk("busy_run", 32'(bus.busy), 32'd1);
    chk("cnt_clear", 32'(bus.sym_count), 32'd0);
    chk("in_ready_run", 32'(bus.in_ready), 32'd1);
    tick();
  endtask

  task automatic finish_frame(input int hold);
    int w = 0;
    #2;
    while (!bus.flush_req && w < 30) begin
      tick();
      #2;
      w++;
    end
    chk("flush_latency", 32'(w), 32'd0);
    for (int k = 0; k < hold; k++) begin
      chk("flush_hold", {29'd0, bus.flush_req, bus.frame_done, bus.busy}, 32'b101);
      tick();
      #2;
    end
    bus.flush_ack = 1'b1;
    chk("flush_req_at_ack", 32'(bus.flush_req), 32'd1);
    tick();
    bus.flush_ack = 1'b0;
    #2;
    chk("frame_done", {29'd0, bus.frame_done, bus.busy, bus.flush_req}, 32'b100);
    tick();
    #2;
    chk("frame_done_pulse", 32'(bus.frame_done), 32'd0);
    tick();
  endtask

  // pat bit i = in_valid in slot i; gap slots also carry in_last, which must be ignored.
  task automatic run_frame(input logic [31:0] pat, input int len, input int hold,
                           input logic [7:0] base);
    int acc = 0;
    for (int i = 0; i < len + 4; i++) begin
      bus.in_valid = bitat(pat, len, i);
      bus.in_last  = (i < len) && ((i == len - 1) || !pat[i]);
      cur_tag      = base + 8'(i);
      if (bitat(pat, len, i)) sb.push_back(base + 8'(i));
      #2;
      chk("in_ready", 32'(bus.in_ready), 32'(i <= len - 1));
      chk("en_s2_3", 32'(bus.en_s2_3), 32'(bitat(pat, len, i - 1)));
      chk("en_final", 32'(bus.en_final), 32'(bitat(pat, len, i - 2)));
      chk("out_valid", 32'(bus.out_valid), 32'(bitat(pat, len, i - 3)));
      chk("sym_count", 32'(bus.sym_count), 32'((acc > CMAX) ? CMAX : acc));
      if (bitat(pat, len, i)) acc++;
      tick();
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    finish_frame(hold);
    #2;
    chk("sym_count_final", 32'(bus.sym_count), 32'((acc > CMAX) ? CMAX : acc));
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n         = 1'b1;
    bus.start     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;
    bus.flush_ack = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("reset_outs", 32'(outs()), 32'd0);
    chk("reset_cnt", 32'(bus.sym_count), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    #2;
    chk("idle_outs", 32'(outs()), 32'd0);
    tick();

    // T1: four back-to-back symbols
    start_frame();
    run_frame(32'hF, 4, 1, 8'd1);

    // T2: stall with the pipe full
    start_frame();
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1;
      cur_tag      = 8'd11 + 8'(i);
      sb.push_back(8'd11 + 8'(i));
      tick();
    end
    bus.in_last   = 1'b1;
    cur_tag       = 8'd14;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #2;
      chk("stall_ctrl", {27'd0, bus.in_ready, bus.en_s1_2, bus.en_s2_3, bus.en_final,
                         bus.out_valid}, 32'b00001);
      chk("stall_cnt", 32'(bus.sym_count), 32'd3);
      tick();
    end
    bus.out_ready = 1'b1;
    sb.push_back(8'd14);
    #2;
    chk("release_ctrl", {29'd0, bus.in_ready, bus.en_s1_2, bus.en_final}, 32'b111);
    tick();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    finish_frame(0);
    chk("t2_sb_empty", 32'(sb.size()), 32'd0);

    // T3: valid gaps 1,0,1,0,1
    start_frame();
    run_frame(32'b10101, 5, 0, 8'd21);

    // T4: asynchronous reset during DRAIN
    start_frame();
    bus.in_valid = 1'b1;
    cur_tag      = 8'd31;
    sb.push_back(8'd31);
    tick();
    bus.in_last  = 1'b1;
    cur_tag      = 8'd32;
    sb.push_back(8'd32);
    tick();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    #2;
    chk("drain_v23", {30'd0, bus.en_final, bus.in_ready}, 32'b10);
    rst_n = 1'b0;
    #1;
    chk("async_reset_outs", 32'(outs()), 32'd0);
    chk("async_reset_cnt", 32'(bus.sym_count), 32'd0);
    sb.delete();
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    start_frame();
    run_frame(32'h1, 1, 0, 8'd35);

    // T5: stray start/flush_ack in RUN, long flush hold
    start_frame();
    bus.start     = 1'b1;
    bus.flush_ack = 1'b1;
    tick();
    bus.start     = 1'b0;
    bus.flush_ack = 1'b0;
    #2;
    chk("stray_ignored", {27'd0, bus.enc_init, bus.busy, bus.in_ready, bus.flush_req,
                          bus.frame_done}, 32'b01100);
    tick();
    run_frame(32'h7, 3, 10, 8'd41);

    // T6: counter saturation
    start_frame();
    run_frame(32'hFFFFF, 20, 1, 8'd51);

    chk("sb_empty_end", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
